// File: rtl/irda_fir_rx_ctrl.sv
// FIR (4 Mb/s, 4PPM) receive sequencer: locks on preamble and start flag,
// restarts the 4PPM decoder, forwards decoded bits and ends or aborts frames.
module irda_fir_rx_ctrl #(
  parameter int PA_MIN   = 4,
  parameter int MAX_SYMS = 16384
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       fir_rx_en,
  input  logic       fir_rx8_enable,
  input  logic       fd_o,
  input  logic       ppmd_o,
  input  logic       ppmd_bad_chip,
  output logic       ppmd_restart,
  output logic       rx_bit,
  output logic       rx_bit_valid,
  output logic       rx_frame_start,
  output logic       rx_frame_end,
  output logic       rx_frame_abort,
  output logic       rx_active,
  output logic [2:0] rx_state
);

  localparam logic [15:0] PA  = 16'b1000_0100_0010_0001;
  localparam logic [31:0] STA = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
  localparam logic [31:0] STO = 32'b0000_1100_0000_1100_0000_0110_0000_0110;
  localparam int          SYM_W   = $clog2(MAX_SYMS + 1);
  localparam logic [7:0]  PA_MIN8 = 8'(PA_MIN);
  localparam logic [SYM_W-1:0] SYM_MAX = SYM_W'(MAX_SYMS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    STOP_CHK = 3'd4
  } state_t;

  state_t           state_q;
  // The live chip completes the windows, so only 31 history chips are stored.
  logic [30:0]      sh_q;
  logic [7:0]       pa_cnt_q;
  logic [7:0]       pa_cnt_d;
  logic [3:0]       ccnt_q;
  logic [4:0]       scnt_q;
  logic [1:0]       ph_q;
  logic [SYM_W-1:0] sym_q;
  logic [SYM_W-1:0] sym_d;
  logic [3:0]       bad_cnt_q;
  logic [3:0]       bad_cnt_d;
  logic             first_q;
  logic             rx_bit_q;
  logic             rx_bit_valid_q;
  logic             start_q;
  logic             end_q;
  logic             abort_q;

  logic [15:0]      win16;
  logic [31:0]      win32;
  logic             pa_hit;
  logic             bit_slot;

  assign win16    = {sh_q[14:0], fd_o};
  assign win32    = {sh_q, fd_o};
  assign pa_hit   = (win16 == PA);
  assign pa_cnt_d = (pa_cnt_q == 8'hFF) ? pa_cnt_q : pa_cnt_q + 8'd1;
  assign sym_d    = sym_q + SYM_W'(1);
  assign bad_cnt_d = bad_cnt_q + 4'd1;
  // Phases 1 and 3 carry decoder bits; symbol 0 only fills the decoder.
  assign bit_slot = ph_q[0] & (sym_q != '0);

  assign ppmd_restart   = fir_rx8_enable & (state_q == DATA) & first_q;
  assign rx_bit         = rx_bit_q;
  assign rx_bit_valid   = rx_bit_valid_q;
  assign rx_frame_start = start_q;
  assign rx_frame_end   = end_q;
  assign rx_frame_abort = abort_q;
  assign rx_active      = (state_q == DATA) || (state_q == STOP_CHK);
  assign rx_state       = state_q;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q        <= IDLE;
      sh_q           <= '0;
      pa_cnt_q       <= '0;
      ccnt_q         <= '0;
      scnt_q         <= '0;
      ph_q           <= '0;
      sym_q          <= '0;
      bad_cnt_q      <= '0;
      first_q        <= 1'b0;
      rx_bit_q       <= 1'b0;
      rx_bit_valid_q <= 1'b0;
      start_q        <= 1'b0;
      end_q          <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      rx_bit_valid_q <= 1'b0;
      start_q        <= 1'b0;
      end_q          <= 1'b0;
      abort_q        <= 1'b0;

      if (fir_rx8_enable) begin
        sh_q <= win32[30:0];
      end

      if (!fir_rx_en) begin
        state_q <= IDLE;
        first_q <= 1'b0;
      end else if (fir_rx8_enable) begin
        case (state_q)
          IDLE: begin
            if (pa_hit) begin
              state_q  <= PREAMBLE;
              pa_cnt_q <= 8'd1;
              ccnt_q   <= '0;
            end
          end

          PREAMBLE: begin
            ccnt_q <= ccnt_q + 4'd1;
            if (ccnt_q == 4'd15) begin
              if (!pa_hit) begin
                state_q <= IDLE;
              end else begin
                pa_cnt_q <= pa_cnt_d;
                if (pa_cnt_d >= PA_MIN8) begin
                  state_q <= START;
                  scnt_q  <= '0;
                end
              end
            end
          end

          // Each further preamble symbol re-arms the 32-chip start-flag search.
          START: begin
            scnt_q <= scnt_q + 5'd1;
            if (scnt_q == 5'd15 && pa_hit) begin
              scnt_q <= '0;
            end else if (scnt_q == 5'd31) begin
              if (win32 == STA) begin
                state_q <= DATA;
                start_q <= 1'b1;
                ph_q    <= '0;
                sym_q   <= '0;
                first_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end

          DATA: begin
            first_q <= 1'b0;
            ph_q    <= ph_q + 2'd1;
            if (ph_q == 2'd3) begin
              sym_q <= sym_d;
              if (ppmd_bad_chip) begin
                state_q   <= STOP_CHK;
                bad_cnt_q <= 4'd1;
              end else if (sym_d == SYM_MAX) begin
                state_q <= IDLE;
                abort_q <= 1'b1;
              end else if (bit_slot) begin
                rx_bit_valid_q <= 1'b1;
                rx_bit_q       <= ppmd_o;
              end
            end else if (bit_slot) begin
              rx_bit_valid_q <= 1'b1;
              rx_bit_q       <= ppmd_o;
            end
          end

          // Eight illegal symbols must spell the stop flag, otherwise abort.
          STOP_CHK: begin
            ph_q <= ph_q + 2'd1;
            if (ph_q == 2'd3) begin
              bad_cnt_q <= bad_cnt_d;
              if (bad_cnt_d == 4'd8) begin
                state_q <= IDLE;
                if (win32 == STO) begin
                  end_q <= 1'b1;
                end else begin
                  abort_q <= 1'b1;
                end
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irda_fir_rx_ctrl.sv
// Directed bench for irda_fir_rx_ctrl; the bench plays the chip source and the
// 4PPM decoder, presenting each symbol's own bits at chip phases 1 and 3.
module tb_irda_fir_rx_ctrl;

  logic       clock;
  logic       wbRst;
  logic       rxEn;
  logic       strobe;
  logic       fdIn;
  logic       ppmdBit;
  logic       ppmdBad;

  logic       restart;
  logic       rxBit;
  logic       rxBitValid;
  logic       frameStart;
  logic       frameEnd;
  logic       frameAbort;
  logic       rxActive;
  logic [2:0] rxState;

  logic       restart5;
  logic       rxBit5;
  logic       rxBitValid5;
  logic       frameStart5;
  logic       frameEnd5;
  logic       frameAbort5;
  logic       rxActive5;
  logic [2:0] rxState5;

  int errorCount = 0;
  int checkCount = 0;

  int startCnt = 0, endCnt = 0, abortCnt = 0, restartCnt = 0, lockCnt = 0;
  int abort5Cnt = 0, bit5Cnt = 0, restart5Cnt = 0, restart5NoStrobe = 0;
  bit bitQ[$];

  logic lastRestart5;
  logic firstRestart5;
  logic laterRestart5;

  logic [31:0] paWord  = 32'h0000_8421;
  logic [31:0] staWord = 32'b0000_1100_0000_1100_0110_0000_0110_0000;

  irda_fir_rx_ctrl dut (
    .clk(clock), .wb_rst_i(wbRst), .fir_rx_en(rxEn), .fir_rx8_enable(strobe),
    .fd_o(fdIn), .ppmd_o(ppmdBit), .ppmd_bad_chip(ppmdBad),
    .ppmd_restart(restart), .rx_bit(rxBit), .rx_bit_valid(rxBitValid),
    .rx_frame_start(frameStart), .rx_frame_end(frameEnd),
    .rx_frame_abort(frameAbort), .rx_active(rxActive), .rx_state(rxState)
  );

  irda_fir_rx_ctrl #(.PA_MIN(4), .MAX_SYMS(8)) dutShort (
    .clk(clock), .wb_rst_i(wbRst), .fir_rx_en(rxEn), .fir_rx8_enable(strobe),
    .fd_o(fdIn), .ppmd_o(ppmdBit), .ppmd_bad_chip(ppmdBad),
    .ppmd_restart(restart5), .rx_bit(rxBit5), .rx_bit_valid(rxBitValid5),
    .rx_frame_start(frameStart5), .rx_frame_end(frameEnd5),
    .rx_frame_abort(frameAbort5), .rx_active(rxActive5), .rx_state(rxState5)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Output monitor, sampled on the falling edge so every registered pulse is seen once.
  always @(negedge clock) begin
    if (!wbRst) begin
      if (frameStart) startCnt++;
      if (frameEnd) endCnt++;
      if (frameAbort) abortCnt++;
      if (restart) restartCnt++;
      if (rxState == 3'd2 || rxState == 3'd3) lockCnt++;
      if (rxBitValid) bitQ.push_back(rxBit);
      if (frameAbort5) abort5Cnt++;
      if (rxBitValid5) bit5Cnt++;
      if (restart5) restart5Cnt++;
      if (restart5 && !strobe) restart5NoStrobe++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One chip: strobe high for one clock, then one quiet clock.
  task automatic applyStimulus(input logic chip, input logic bitVal, input logic badVal);
    @(posedge clock); #1;
    fdIn    = chip;
    ppmdBit = bitVal;
    ppmdBad = badVal;
    strobe  = 1'b1;
    #1 lastRestart5 = restart5;
    @(posedge clock); #1;
    strobe  = 1'b0;
    ppmdBit = 1'b0;
    ppmdBad = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(w[i], 1'b0, 1'b0);
  endtask

  task automatic sendZeros(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendPreambleStart(input int paCount);
    for (int i = 0; i < paCount; i++) sendWord(paWord, 16);
    sendWord(staWord, 32);
  endtask

  task automatic sendSym(input logic [3:0] chips, input logic b0, input logic b1, input logic bad);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(chips[3-i], (i == 1) ? b0 : ((i == 3) ? b1 : 1'b0), (i == 3) ? bad : 1'b0);
      if (i == 0) firstRestart5 = lastRestart5;
      else laterRestart5 = laterRestart5 | lastRestart5;
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int sBase, eBase, aBase, rBase, lBase, bBase;
    int a5Base, b5Base, r5Base;
    logic [5:0] gotBits;
    logic [31:0] stoSyms [8];

    wbRst = 1'b1; rxEn = 1'b1; strobe = 1'b0;
    fdIn = 1'b0; ppmdBit = 1'b0; ppmdBad = 1'b0;
    lastRestart5 = 1'b0; firstRestart5 = 1'b0; laterRestart5 = 1'b0;
    stoSyms = '{32'h0, 32'hC, 32'h0, 32'hC, 32'h0, 32'h6, 32'h0, 32'h6};

    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetState", rxState, 0);
    checkOutput("resetOutputs", {restart, rxBit, rxBitValid, frameStart, frameEnd, frameAbort, rxActive}, 0);
    wbRst = 1'b0;
    settle();

    // Test 1: full frame with 16 PA, four data symbols and a stop flag.
    sBase = startCnt; eBase = endCnt; aBase = abortCnt; rBase = restartCnt; bBase = bitQ.size();
    sendZeros(8);
    sendPreambleStart(16);
    settle();
    checkOutput("t1StartPulse", startCnt - sBase, 1);
    checkOutput("t1StateData", rxState, 3);
    checkOutput("t1Active", rxActive, 1);
    sendSym(4'b1000, 1'b0, 1'b0, 1'b0);
    sendSym(4'b0100, 1'b1, 1'b0, 1'b0);
    sendSym(4'b0010, 1'b0, 1'b1, 1'b0);
    sendSym(4'b0001, 1'b1, 1'b1, 1'b0);
    sendSym(stoSyms[0][3:0], 1'b0, 1'b0, 1'b1);
    checkOutput("t1StateStopChk", rxState, 4);
    for (int i = 1; i < 8; i++) sendSym(stoSyms[i][3:0], 1'b0, 1'b0, 1'b1);
    settle();
    checkOutput("t1EndPulse", endCnt - eBase, 1);
    checkOutput("t1NoAbort", abortCnt - aBase, 0);
    checkOutput("t1StateIdle", rxState, 0);
    checkOutput("t1RestartOnce", restartCnt - rBase, 1);
    // The first stop symbol's phase-1 slot is forwarded before its illegal flag.
    checkOutput("t1BitCount", bitQ.size() - bBase, 7);
    gotBits = '0;
    for (int i = 0; i < 6; i++) if (bBase + i < bitQ.size()) gotBits[5-i] = bitQ[bBase+i];
    checkOutput("t1Bits", gotBits, 6'b100111);

    // Test 2: one preamble symbol short of PA_MIN never reaches the start search.
    sBase = startCnt; lBase = lockCnt;
    sendZeros(8);
    sendPreambleStart(3);
    sendZeros(8);
    settle();
    checkOutput("t2NoStart", startCnt - sBase, 0);
    checkOutput("t2NeverLocked", lockCnt - lBase, 0);
    checkOutput("t2StateIdle", rxState, 0);

    // Test 3: illegal symbol mid-frame then seven legal symbols aborts the frame.
    aBase = abortCnt; eBase = endCnt; bBase = bitQ.size();
    sendZeros(8);
    sendPreambleStart(4);
    sendSym(4'b1000, 1'b0, 1'b0, 1'b0);
    sendSym(4'b0100, 1'b1, 1'b0, 1'b0);
    sendSym(4'b0110, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) sendSym(4'b1000, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("t3NoAbortYet", abortCnt - aBase, 0);
    checkOutput("t3StateStopChk", rxState, 4);
    sendSym(4'b1000, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("t3AbortPulse", abortCnt - aBase, 1);
    checkOutput("t3NoEnd", endCnt - eBase, 0);
    checkOutput("t3StateIdle", rxState, 0);
    checkOutput("t3BitCount", bitQ.size() - bBase, 3);
    gotBits = '0;
    for (int i = 0; i < 3; i++) if (bBase + i < bitQ.size()) gotBits[2-i] = bitQ[bBase+i];
    checkOutput("t3Bits", gotBits, 6'b000100);

    // Test 4: dropping the enable mid-DATA returns to IDLE silently.
    aBase = abortCnt; eBase = endCnt; rBase = restartCnt;
    sendZeros(8);
    sendPreambleStart(4);
    sendSym(4'b1000, 1'b0, 1'b0, 1'b0);
    sendSym(4'b0100, 1'b1, 1'b0, 1'b0);
    rxEn = 1'b0;
    @(posedge clock); #1;
    checkOutput("t4StateIdle", rxState, 0);
    checkOutput("t4Inactive", rxActive, 0);
    sendSym(4'b0010, 1'b0, 1'b1, 1'b0);
    sendWord(paWord, 16);
    settle();
    checkOutput("t4StillIdle", rxState, 0);
    checkOutput("t4NoEndAbort", (endCnt - eBase) + (abortCnt - aBase), 0);
    checkOutput("t4RestartOnce", restartCnt - rBase, 1);
    rxEn = 1'b1;

    // Test 5: MAX_SYMS=8 instance aborts on the eighth data symbol.
    a5Base = abort5Cnt; b5Base = bit5Cnt; r5Base = restart5Cnt;
    sendZeros(8);
    sendPreambleStart(4);
    laterRestart5 = 1'b0;
    sendSym(4'b0001, 1'b1, 1'b1, 1'b0);
    checkOutput("t5RestartFirstChip", firstRestart5, 1);
    for (int i = 1; i < 7; i++) sendSym(4'b0001, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("t5NoAbortYet", abort5Cnt - a5Base, 0);
    checkOutput("t5StateData", rxState5, 3);
    sendSym(4'b0001, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("t5AbortPulse", abort5Cnt - a5Base, 1);
    checkOutput("t5StateIdle", rxState5, 0);
    checkOutput("t5BitCount", bit5Cnt - b5Base, 13);
    checkOutput("t5LongStillData", rxState, 3);
    sendSym(4'b0001, 1'b1, 1'b1, 1'b0);
    sendSym(4'b0001, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("t5StaysIdle", rxState5, 0);
    checkOutput("t5RestartOneClk", restart5Cnt - r5Base, 1);
    checkOutput("t5RestartWithStrobe", restart5NoStrobe, 0);
    checkOutput("t5RestartNotLater", laterRestart5, 0);
    rxEn = 1'b0;
    @(posedge clock); #1;
    rxEn = 1'b1;

    // Test 6: reset during STOP_CHK clears everything at once, then relock.
    aBase = abortCnt; eBase = endCnt;
    sendZeros(8);
    sendPreambleStart(4);
    sendSym(4'b1000, 1'b0, 1'b0, 1'b0);
    sendSym(4'b0100, 1'b1, 1'b0, 1'b0);
    sendSym(4'b0110, 1'b1, 1'b0, 1'b1);
    checkOutput("t6StateStopChk", rxState, 4);
    checkOutput("t6BitHeld", rxBit, 1);
    #2 wbRst = 1'b1;
    #1;
    checkOutput("t6ResetState", rxState, 0);
    checkOutput("t6ResetOutputs", {restart, rxBit, rxBitValid, frameStart, frameEnd, frameAbort, rxActive}, 0);
    repeat (2) @(posedge clock);
    #1 wbRst = 1'b0;
    sBase = startCnt;
    sendZeros(8);
    sendPreambleStart(4);
    settle();
    checkOutput("t6Relock", startCnt - sBase, 1);
    checkOutput("t6RelockState", rxState, 3);
    checkOutput("t6NoEndAbort", (endCnt - eBase) + (abortCnt - aBase), 0);
    rxEn = 1'b0;
    settle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
